// File: rtl/regfile_sb.sv
// Parametrised register file with hardwired zero register, optional write-to-read
// bypass and a per-register pending scoreboard for decode-stage stall generation.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  ctrl_writeEn,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_issueEn,
  input  logic [ADDR_WIDTH-1:0] ctrl_issueReg,
  input  logic                  ctrl_flush,
  output logic                  pendingA,
  output logic                  pendingB,
  output logic                  stall,
  output logic [ADDR_WIDTH:0]   pendingCount
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];
  logic [DEPTH-1:1]      pend;
  logic [DEPTH-1:1]      pendNext;
  logic [ADDR_WIDTH:0]   countNext;
  logic [DATA_WIDTH-1:0] storedA, storedB;
  logic                  pendRawA, pendRawB;
  logic                  fwdA, fwdB;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int unsigned i = 1; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (ctrl_writeEn && ctrl_writeReg == ADDR_WIDTH'(i)) regs[i] <= data_writeReg;
      end
    end
  end

  // Forwarding is gated by reset so read ports show 0 while reset is held.
  always_comb begin
    fwdA = (BYPASS != 0) && ctrl_reset_n && ctrl_writeEn &&
           (ctrl_writeReg == ctrl_readRegA) && (ctrl_readRegA != '0);
    fwdB = (BYPASS != 0) && ctrl_reset_n && ctrl_writeEn &&
           (ctrl_writeReg == ctrl_readRegB) && (ctrl_readRegB != '0);
  end

  always_comb begin
    storedA  = '0;
    storedB  = '0;
    pendRawA = 1'b0;
    pendRawB = 1'b0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (ctrl_readRegA == ADDR_WIDTH'(i)) begin
        storedA  = regs[i];
        pendRawA = pend[i];
      end
      if (ctrl_readRegB == ADDR_WIDTH'(i)) begin
        storedB  = regs[i];
        pendRawB = pend[i];
      end
    end
  end

  always_comb begin
    data_readRegA = fwdA ? data_writeReg : storedA;
    data_readRegB = fwdB ? data_writeReg : storedB;
    pendingA      = pendRawA & ~fwdA;
    pendingB      = pendRawB & ~fwdB;
    stall         = pendingA | pendingB;
  end

  // Issue is checked before write so a same-index issue+write keeps the bit set.
  always_comb begin
    pendNext  = pend;
    countNext = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (ctrl_flush)                                            pendNext[i] = 1'b0;
      else if (ctrl_issueEn && ctrl_issueReg == ADDR_WIDTH'(i)) pendNext[i] = 1'b1;
      else if (ctrl_writeEn && ctrl_writeReg == ADDR_WIDTH'(i)) pendNext[i] = 1'b0;
      countNext = countNext + (ADDR_WIDTH + 1)'(pendNext[i]);
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      pend         <= '0;
      pendingCount <= '0;
    end else begin
      pend         <= pendNext;
      pendingCount <= countNext;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: bypass and non-bypass instances share stimulus and are
// compared against an array-based model of registers and pending bits.
module tb_regfile_sb;

  logic        clock;
  logic        rstN;
  logic        we, ie, fl;
  logic [4:0]  wr, ra, rb, ir;
  logic [31:0] wd;

  logic [31:0] rdA0, rdB0, rdA1, rdB1;
  logic        pA0, pB0, st0, pA1, pB1, st1;
  logic [5:0]  cnt0, cnt1;

  logic [31:0] mReg [32];
  bit   [31:0] mPend;
  int          nChecks;
  int          nFails;

  regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dutNoByp (
    .clock(clock), .ctrl_reset_n(rstN), .ctrl_writeEn(we), .ctrl_writeReg(wr),
    .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rdA0), .data_readRegB(rdB0), .ctrl_issueEn(ie),
    .ctrl_issueReg(ir), .ctrl_flush(fl), .pendingA(pA0), .pendingB(pB0),
    .stall(st0), .pendingCount(cnt0));

  regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dutByp (
    .clock(clock), .ctrl_reset_n(rstN), .ctrl_writeEn(we), .ctrl_writeReg(wr),
    .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rdA1), .data_readRegB(rdB1), .ctrl_issueEn(ie),
    .ctrl_issueReg(ir), .ctrl_flush(fl), .pendingA(pA1), .pendingB(pB1),
    .stall(st1), .pendingCount(cnt1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void modelClear();
    for (int i = 0; i < 32; i++) mReg[i] = '0;
    mPend = '0;
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] idx, input bit byp);
    if (!rstN || idx == 0) return '0;
    if (byp && we && wr == idx) return wd;
    return mReg[idx];
  endfunction

  function automatic bit expPend(input logic [4:0] idx, input bit byp);
    if (!rstN || idx == 0) return 1'b0;
    if (byp && we && wr == idx) return 1'b0;
    return mPend[idx];
  endfunction

  function automatic logic [4:0] rIdx();
    if ($urandom % 2 == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [31:0] fillVal(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'h5A00_00C3;
  endfunction

  task automatic idle();
    we = 0; wr = 0; wd = 0; ra = 0; rb = 0; ie = 0; ir = 0; fl = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    if (rstN) begin
      if (we && wr != 0) mReg[wr] = wd;
      if (fl) mPend = '0;
      else begin
        if (we && wr != 0) mPend[wr] = 1'b0;
        if (ie && ir != 0) mPend[ir] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    nChecks++; if (cnt0 !== 6'd0 || cnt1 !== 6'd0) begin nFails++; $display("FAIL reset_count got %0d/%0d exp 0", cnt0, cnt1); end
    nChecks++; if (st0 !== 1'b0 || st1 !== 1'b0) begin nFails++; $display("FAIL reset_stall got %b/%b exp 0", st0, st1); end
    ra = 5; rb = 31; #1;
    nChecks++; if (rdA0 !== 32'd0 || rdB1 !== 32'd0) begin nFails++; $display("FAIL reset_read got %h/%h exp 0", rdA0, rdB1); end
    ra = 0; rb = 0;
  endtask

  task automatic test_write_read();
    idle(); we = 1; wr = 3; wd = 32'hDEADBEEF; tick();
    idle(); ra = 3; #1;
    nChecks++; if (rdA0 !== 32'hDEADBEEF || rdA1 !== 32'hDEADBEEF) begin nFails++; $display("FAIL wr3 got %h/%h exp deadbeef", rdA0, rdA1); end
    we = 1; wr = 0; wd = 32'd123; rb = 0; #1;
    nChecks++; if (rdB0 !== 32'd0 || rdB1 !== 32'd0) begin nFails++; $display("FAIL wr0_same got %h/%h exp 0", rdB0, rdB1); end
    tick(); idle(); rb = 0; #1;
    nChecks++; if (rdB0 !== 32'd0 || rdB1 !== 32'd0) begin nFails++; $display("FAIL wr0_next got %h/%h exp 0", rdB0, rdB1); end
    for (int i = 1; i < 32; i++) begin
      we = 1; wr = 5'(i); wd = fillVal(i); tick();
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      ra = 5'(i); rb = 5'(32 - i); #1;
      nChecks++; if (rdA0 !== fillVal(i) || rdA1 !== fillVal(i)) begin nFails++; $display("FAIL fill_A idx %0d got %h/%h exp %h", i, rdA0, rdA1, fillVal(i)); end
      nChecks++; if (rdB0 !== fillVal(32 - i) || rdB1 !== fillVal(32 - i)) begin nFails++; $display("FAIL fill_B idx %0d got %h/%h exp %h", 32 - i, rdB0, rdB1, fillVal(32 - i)); end
      tick();
    end
  endtask

  task automatic test_bypass();
    idle(); we = 1; wr = 7; wd = 32'd11; tick();
    we = 1; wr = 7; wd = 32'd42; ra = 7; #1;
    nChecks++; if (rdA1 !== 32'd42) begin nFails++; $display("FAIL bypass_same got %0d exp 42", rdA1); end
    nChecks++; if (rdA0 !== 32'd11) begin nFails++; $display("FAIL nobypass_same got %0d exp 11", rdA0); end
    tick(); idle(); ra = 7; #1;
    nChecks++; if (rdA0 !== 32'd42 || rdA1 !== 32'd42) begin nFails++; $display("FAIL bypass_next got %0d/%0d exp 42", rdA0, rdA1); end
  endtask

  task automatic test_scoreboard();
    idle(); ie = 1; ir = 9; tick();
    idle(); ra = 9; #1;
    nChecks++; if (pA0 !== 1'b1 || pA1 !== 1'b1) begin nFails++; $display("FAIL issue9_pend got %b/%b exp 1", pA0, pA1); end
    nChecks++; if (st0 !== 1'b1 || st1 !== 1'b1) begin nFails++; $display("FAIL issue9_stall got %b/%b exp 1", st0, st1); end
    nChecks++; if (cnt0 !== 6'd1 || cnt1 !== 6'd1) begin nFails++; $display("FAIL issue9_count got %0d/%0d exp 1", cnt0, cnt1); end
    we = 1; wr = 9; wd = 32'd5; #1;
    nChecks++; if (st1 !== 1'b0) begin nFails++; $display("FAIL clear_bypass_stall got %b exp 0", st1); end
    nChecks++; if (st0 !== 1'b1) begin nFails++; $display("FAIL clear_nobypass_stall got %b exp 1", st0); end
    tick(); idle(); ra = 9; #1;
    nChecks++; if (cnt0 !== 6'd0 || cnt1 !== 6'd0) begin nFails++; $display("FAIL clear_count got %0d/%0d exp 0", cnt0, cnt1); end
    nChecks++; if (st0 !== 1'b0 || rdA0 !== 32'd5) begin nFails++; $display("FAIL clear_next stall %b data %0d exp 0/5", st0, rdA0); end
  endtask

  task automatic test_simultaneous();
    idle(); fl = 1; tick();
    idle(); ie = 1; ir = 6; tick();
    idle(); ie = 1; ir = 4; we = 1; wr = 6; wd = 32'd1; tick();
    idle(); ra = 4; rb = 6; #1;
    nChecks++; if (pA0 !== 1'b1 || pA1 !== 1'b1) begin nFails++; $display("FAIL iss4_wr6_p4 got %b/%b exp 1", pA0, pA1); end
    nChecks++; if (pB0 !== 1'b0 || pB1 !== 1'b0) begin nFails++; $display("FAIL iss4_wr6_p6 got %b/%b exp 0", pB0, pB1); end
    nChecks++; if (cnt0 !== 6'd1 || cnt1 !== 6'd1) begin nFails++; $display("FAIL iss4_wr6_count got %0d/%0d exp 1", cnt0, cnt1); end
    idle(); ie = 1; ir = 4; we = 1; wr = 4; wd = 32'd2; tick();
    idle(); ra = 4; #1;
    nChecks++; if (pA0 !== 1'b1 || pA1 !== 1'b1 || cnt1 !== 6'd1) begin nFails++; $display("FAIL iss_wr_same p4 %b/%b count %0d exp 1/1/1", pA0, pA1, cnt1); end
    idle(); ie = 1; ir = 0; tick();
    idle(); ra = 0; #1;
    nChecks++; if (cnt0 !== 6'd1 || pA1 !== 1'b0 || pA0 !== 1'b0) begin nFails++; $display("FAIL issue0 count %0d pend %b/%b exp 1/0/0", cnt0, pA0, pA1); end
  endtask

  task automatic test_flush();
    idle(); fl = 1; tick();
    for (int i = 1; i < 32; i++) begin
      idle(); ie = 1; ir = 5'(i); tick();
    end
    idle(); #1;
    nChecks++; if (cnt0 !== 6'd31 || cnt1 !== 6'd31) begin nFails++; $display("FAIL full_count got %0d/%0d exp 31", cnt0, cnt1); end
    fl = 1; ie = 1; ir = 2; tick();
    idle(); ra = 2; #1;
    nChecks++; if (cnt0 !== 6'd0 || cnt1 !== 6'd0) begin nFails++; $display("FAIL flush_count got %0d/%0d exp 0", cnt0, cnt1); end
    nChecks++; if (pA0 !== 1'b0 || pA1 !== 1'b0 || st1 !== 1'b0) begin nFails++; $display("FAIL flush_p2 got %b/%b stall %b exp 0", pA0, pA1, st1); end
  endtask

  task automatic test_random();
    logic [31:0] gA, gB, eA, eB;
    logic        gPA, gPB, gSt, ePA, ePB;
    logic [5:0]  gCnt;
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom % 2); wr = rIdx(); wd = $urandom;
      ra = rIdx(); rb = rIdx();
      ie = 1'($urandom % 2); ir = rIdx(); fl = ($urandom % 16) == 0;
      #1;
      for (int b = 0; b < 2; b++) begin
        gA = b ? rdA1 : rdA0; gB = b ? rdB1 : rdB0;
        gPA = b ? pA1 : pA0; gPB = b ? pB1 : pB0;
        gSt = b ? st1 : st0; gCnt = b ? cnt1 : cnt0;
        eA = expRead(ra, b == 1); eB = expRead(rb, b == 1);
        ePA = expPend(ra, b == 1); ePB = expPend(rb, b == 1);
        nChecks++; if (gA !== eA || gB !== eB) begin nFails++; $display("FAIL rand_read byp%0d cyc %0d got %h/%h exp %h/%h", b, n, gA, gB, eA, eB); end
        nChecks++; if (gPA !== ePA || gPB !== ePB || gSt !== (ePA | ePB)) begin nFails++; $display("FAIL rand_pend byp%0d cyc %0d got %b%b%b exp %b%b%b", b, n, gPA, gPB, gSt, ePA, ePB, ePA | ePB); end
        nChecks++; if (gCnt !== 6'($countones(mPend))) begin nFails++; $display("FAIL rand_count byp%0d cyc %0d got %0d exp %0d", b, n, gCnt, $countones(mPend)); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    idle(); we = 1; wr = 5; wd = 32'd77; tick();
    idle(); ie = 1; ir = 8; tick();
    we = 1; wr = 5; wd = 32'd99; ra = 5; rb = 8; ie = 1; ir = 3; fl = 0;
    #2; rstN = 0; modelClear(); #1;
    nChecks++; if (rdA0 !== 32'd0 || rdA1 !== 32'd0) begin nFails++; $display("FAIL midreset_read got %h/%h exp 0", rdA0, rdA1); end
    nChecks++; if (cnt0 !== 6'd0 || cnt1 !== 6'd0 || st0 !== 1'b0 || st1 !== 1'b0) begin nFails++; $display("FAIL midreset_sb count %0d/%0d stall %b/%b exp 0", cnt0, cnt1, st0, st1); end
    tick();
    nChecks++; if (rdA0 !== 32'd0 || rdA1 !== 32'd0 || cnt1 !== 6'd0) begin nFails++; $display("FAIL midreset_edge read %h/%h count %0d exp 0", rdA0, rdA1, cnt1); end
    idle(); ra = 5; rstN = 1; #1;
    nChecks++; if (rdA0 !== 32'd0 || rdA1 !== 32'd0 || cnt0 !== 6'd0) begin nFails++; $display("FAIL postreset read %h/%h count %0d exp 0", rdA0, rdA1, cnt0); end
  endtask

  initial begin
    nChecks = 0; nFails = 0;
    idle(); modelClear();
    rstN = 0; #2;
    test_reset();
    #10; rstN = 1;
    tick();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_flush();
    test_random();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
